// File: rtl/vga_pkg.sv
// vga_pkg
// Shared timing constants for the VGA scan generator: default 640x480@60
// timing, derived line/frame totals, sync window bounds, and the colour
// struct used for the registered DAC output.
// Ports: none (package).
package vga_pkg;

   // Width of the internal horizontal/vertical counters.
   localparam int COUNT_W = 16;

   // Default timing.
   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   // First count of the sync window: sync follows visible + front porch.
   function automatic int sync_first(input int visible, input int front);
      return visible + front;
   endfunction

   // Last count of the sync window (inclusive).
   function automatic int sync_last(input int visible, input int front,
                                    input int sync);
      return visible + front + sync - 1;
   endfunction

   localparam int H_TOTAL      = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int V_TOTAL      = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
   localparam int H_SYNC_START = sync_first(DEF_H_VISIBLE, DEF_H_FRONT);
   localparam int H_SYNC_END   = sync_last(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
   localparam int V_SYNC_START = sync_first(DEF_V_VISIBLE, DEF_V_FRONT);
   localparam int V_SYNC_END   = sync_last(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One scan axis (horizontal or vertical): a 0..TOTAL-1 counter that
// advances on en, plus decoded visible and active-low sync flags.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   en            advance the counter this clk
//   count         current position
//   wrap          high in the clk where en moves count from TOTAL-1 to 0
//   visible       count < VISIBLE
//   sync_n        low while count lies in [SYNC_START, SYNC_END]
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int VISIBLE    = DEF_H_VISIBLE,
   parameter int SYNC_START = H_SYNC_START,
   parameter int SYNC_END   = H_SYNC_END
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   output logic [COUNT_W-1:0] count,
   output logic               wrap,
   output logic               visible,
   output logic               sync_n
);

   localparam logic [COUNT_W-1:0] LAST_C  = COUNT_W'(TOTAL - 1);
   localparam logic [COUNT_W-1:0] VIS_C   = COUNT_W'(VISIBLE);
   localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_START);
   localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_END);

   logic [COUNT_W-1:0] count_reg;
   logic [COUNT_W-1:0] count_next;
   logic               at_last;

   assign at_last = (count_reg == LAST_C);

   always_comb begin
      count_next = count_reg;
      if (en) begin
         count_next = at_last ? '0 : count_reg + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count   = count_reg;
   assign wrap    = en && at_last;
   assign visible = (count_reg < VIS_C);
   assign sync_n  = !((count_reg >= SYNC_LO) && (count_reg <= SYNC_HI));

endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator
// Raster scan timing for a VGA DAC. A clock divider produces one pixel_tick
// per CLK_DIV clks; horizontal and vertical axis counters step on that tick.
// The pixel coordinate goes out to a combinational drawer, and the drawer's
// colour plus the sync levels are registered on the tick, so colour and
// syncs leave together one pixel after the coordinate was presented.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   col, row                      coordinate to the drawer (0,0 in blanking)
//   red_in, green_in, blue_in     drawer colour for col/row
//   vga_red, vga_green, vga_blue  DAC colour
//   vga_hsync, vga_vsync          active-low syncs
//   pixel_tick                    one-clk strobe per pixel
//   frame_start                   one-clk strobe when the scan returns to 0,0
module vga_scan_generator
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] col,
   output logic [31:0] row,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   output logic [3:0]  vga_red,
   output logic [3:0]  vga_green,
   output logic [3:0]  vga_blue,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        pixel_tick,
   output logic        frame_start
);

   localparam int LINE_PIXELS = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int FRAME_LINES = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   // A one-bit divider is kept for CLK_DIV=1 so the vector never collapses
   // to zero width; it simply sits at 0 and the tick stays high.
   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]   div_reg;
   logic [DIV_W-1:0]   div_next;
   logic               tick_reg;
   logic [COUNT_W-1:0] h_count;
   logic [COUNT_W-1:0] v_count;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_visible;
   logic               v_visible;
   logic               h_sync_n;
   logic               v_sync_n;
   logic               active;
   rgb_t               rgb_reg;
   rgb_t               rgb_next;
   logic               hsync_reg;
   logic               vsync_reg;
   logic               frame_start_reg;

   always_comb begin
      div_next = div_reg + DIV_W'(1);
      if (div_reg == DIV_LAST) begin
         div_next = '0;
      end
   end

   vga_axis_counter #(
      .TOTAL      (LINE_PIXELS),
      .VISIBLE    (H_VISIBLE),
      .SYNC_START (sync_first(H_VISIBLE, H_FRONT)),
      .SYNC_END   (sync_last(H_VISIBLE, H_FRONT, H_SYNC))
   ) u_h_axis (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (tick_reg),
      .count   (h_count),
      .wrap    (h_wrap),
      .visible (h_visible),
      .sync_n  (h_sync_n)
   );

   // The line counter only moves when the pixel counter wraps, so both
   // return to 0 on the same tick at the bottom-right corner.
   vga_axis_counter #(
      .TOTAL      (FRAME_LINES),
      .VISIBLE    (V_VISIBLE),
      .SYNC_START (sync_first(V_VISIBLE, V_FRONT)),
      .SYNC_END   (sync_last(V_VISIBLE, V_FRONT, V_SYNC))
   ) u_v_axis (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (h_wrap),
      .count   (v_count),
      .wrap    (v_wrap),
      .visible (v_visible),
      .sync_n  (v_sync_n)
   );

   assign active = h_visible && v_visible;

   // Blanking coordinates are pinned to 0,0 so drawer lookups stay in range.
   assign col = active ? 32'(h_count) : 32'd0;
   assign row = active ? 32'(v_count) : 32'd0;

   always_comb begin
      rgb_next = '0;
      if (active) begin
         rgb_next = {red_in, green_in, blue_in};
      end
   end

   // tick_reg is high for exactly the clk in which div_reg == CLK_DIV-1,
   // derived from div_next so it comes straight from a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_reg         <= '0;
         tick_reg        <= 1'b0;
         rgb_reg         <= '0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         div_reg         <= div_next;
         tick_reg        <= (div_next == DIV_LAST);
         frame_start_reg <= v_wrap;
         if (tick_reg) begin
            rgb_reg   <= rgb_next;
            hsync_reg <= h_sync_n;
            vsync_reg <= v_sync_n;
         end
      end
   end

   assign vga_red     = rgb_reg.red;
   assign vga_green   = rgb_reg.green;
   assign vga_blue    = rgb_reg.blue;
   assign vga_hsync   = hsync_reg;
   assign vga_vsync   = vsync_reg;
   assign pixel_tick  = tick_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator
// Runs the scan generator with a reduced raster (24x15 pixels, 16x8
// visible) so whole frames fit in a short run. A drawer drives colour from
// col/row; expected outputs come from a bench-side timing model and a table
// of hand-derived positions.
module tb_vga_scan_generator;

   localparam int CLK_DIV = 2;
   localparam int HV = 16, HF = 2, HS = 3, HB = 3;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;   // 24
   localparam int VT = VV + VF + VS + VB;   // 15
   localparam int FRAME_TICKS = HT * VT;    // 360

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] col, row;
   logic [3:0]  red_in, green_in, blue_in;
   logic [3:0]  vga_red, vga_green, vga_blue;
   logic        vga_hsync, vga_vsync, pixel_tick, frame_start;

   always #5 clk = ~clk;

   vga_scan_generator #(
      .CLK_DIV(CLK_DIV),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .col(col), .row(row),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .pixel_tick(pixel_tick), .frame_start(frame_start)
   );

   // Combinational drawer.
   always_comb begin
      red_in   = col[3:0];
      green_in = row[3:0];
      blue_in  = col[3:0] ^ row[3:0];
   end

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   // Position vectors: at (h,v), right after the tick that lands there.
   typedef struct {
      int         h;
      int         v;
      int         col;
      int         row;
      logic       hs;
      logic       vs;
      logic [3:0] red;
      logic       fs;
   } vec_t;

   vec_t tbl[15];
   exp_t sb_q[$];
   exp_t cur_exp;

   int n_checks = 0;
   int n_fail   = 0;
   int m_div, m_h, m_v;
   bit m_tick, m_fs;
   int clk_cnt = 0, last_fs_clk = 0;
   int tick_cnt, hs_low, vs_low, fs_seen = 0;
   int max_col = 0, max_row = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (model h=%0d v=%0d)", name, act, exp, m_h, m_v);
      end
   endtask

   function automatic bit is_active(input int h, input int v);
      return (h < HV) && (v < VV);
   endfunction

   function automatic exp_t model_out(input int h, input int v);
      exp_t        e;
      logic [31:0] hh, vv;
      hh = h;
      vv = v;
      e.rgb = is_active(h, v) ? {hh[3:0], vv[3:0], hh[3:0] ^ vv[3:0]} : 12'h000;
      e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      return e;
   endfunction

   task automatic release_model();
      m_div    = 0;
      m_h      = 0;
      m_v      = 0;
      m_tick   = 1'b0;
      m_fs     = 1'b0;
      cur_exp  = '{12'h000, 1'b1, 1'b1};
      sb_q.delete();
      last_fs_clk = clk_cnt;
      tick_cnt = 0;
      hs_low   = 0;
      vs_low   = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_col"},   col, 32'd0);
      chk({tag, "_row"},   row, 32'd0);
      chk({tag, "_rgb"},   32'({vga_red, vga_green, vga_blue}), 32'd0);
      chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
      chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
      chk({tag, "_tick"},  32'(pixel_tick), 32'd0);
      chk({tag, "_fs"},    32'(frame_start), 32'd0);
      $display("reset check %s: col=%0d row=%0d hs=%0b vs=%0b", tag, col, row, vga_hsync, vga_vsync);
   endtask

   // One clk: push the expectation for the pixel being sampled, advance the
   // model across the edge, then compare everything the DUT shows.
   task automatic step();
      bit ticked;
      if (m_tick) sb_q.push_back(model_out(m_h, m_v));
      @(posedge clk);
      #1;
      clk_cnt++;
      ticked = m_tick;
      m_fs   = 1'b0;
      if (ticked) begin
         if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
               m_v  = 0;
               m_fs = 1'b1;
            end else begin
               m_v++;
            end
         end else begin
            m_h++;
         end
         if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
      end
      m_div  = (m_div == CLK_DIV - 1) ? 0 : m_div + 1;
      m_tick = (m_div == CLK_DIV - 1);

      chk("pixel_tick",  32'(pixel_tick), 32'(m_tick));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("col", col, is_active(m_h, m_v) ? 32'(m_h) : 32'd0);
      chk("row", row, is_active(m_h, m_v) ? 32'(m_v) : 32'd0);
      chk("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(cur_exp.rgb));
      chk("vga_hsync", 32'(vga_hsync), 32'(cur_exp.hs));
      chk("vga_vsync", 32'(vga_vsync), 32'(cur_exp.vs));
      if (col > max_col) max_col = col;
      if (row > max_row) max_row = row;

      if (ticked) begin
         tick_cnt++;
         if (!vga_hsync) hs_low++;
         if (!vga_vsync) vs_low++;
         for (int k = 0; k < 15; k++) begin
            if (tbl[k].h == m_h && tbl[k].v == m_v) begin
               chk("tbl_col", col, 32'(tbl[k].col));
               chk("tbl_row", row, 32'(tbl[k].row));
               chk("tbl_hsync", 32'(vga_hsync), 32'(tbl[k].hs));
               chk("tbl_vsync", 32'(vga_vsync), 32'(tbl[k].vs));
               chk("tbl_red", 32'(vga_red), 32'(tbl[k].red));
               chk("tbl_fs", 32'(frame_start), 32'(tbl[k].fs));
               $display("vector %0d at h=%0d v=%0d: col=%0d row=%0d hs=%0b vs=%0b red=%0d fs=%0b",
                        k, m_h, m_v, col, row, vga_hsync, vga_vsync, vga_red, frame_start);
            end
         end
      end

      if (m_fs) begin
         chk("frame_clks",   32'(clk_cnt - last_fs_clk), 32'(FRAME_TICKS * CLK_DIV));
         chk("frame_ticks",  32'(tick_cnt), 32'(FRAME_TICKS));
         chk("hsync_low",    32'(hs_low), 32'(HS * VT));
         chk("vsync_low",    32'(vs_low), 32'(VS * HT));
         $display("frame end: clks=%0d ticks=%0d hsync_low=%0d vsync_low=%0d",
                  clk_cnt - last_fs_clk, tick_cnt, hs_low, vs_low);
         fs_seen++;
         last_fs_clk = clk_cnt;
         tick_cnt = 0;
         hs_low   = 0;
         vs_low   = 0;
      end
   endtask

   initial begin
      bit reached;
      int n;

      //         h   v  col row hs vs red fs
      tbl[0]  = '{0,  0,  0,  0, 1, 1, 0, 1};   // frame wrap
      tbl[1]  = '{6,  2,  6,  2, 1, 1, 5, 0};
      tbl[2]  = '{15, 7, 15,  7, 1, 1, 14, 0};  // last visible pixel
      tbl[3]  = '{16, 7,  0,  0, 1, 1, 15, 0};  // first blank, last colour out
      tbl[4]  = '{17, 7,  0,  0, 1, 1, 0, 0};   // blank colour out
      tbl[5]  = '{18, 4,  0,  0, 1, 1, 0, 0};
      tbl[6]  = '{19, 4,  0,  0, 0, 1, 0, 0};   // hsync low, one pixel late
      tbl[7]  = '{21, 4,  0,  0, 0, 1, 0, 0};
      tbl[8]  = '{22, 4,  0,  0, 1, 1, 0, 0};
      tbl[9]  = '{0,  8,  0,  0, 1, 1, 0, 0};
      tbl[10] = '{0, 11,  0,  0, 1, 0, 0, 0};   // vsync low from line 10
      tbl[11] = '{5, 10,  0,  0, 1, 0, 0, 0};
      tbl[12] = '{0, 12,  0,  0, 1, 0, 0, 0};
      tbl[13] = '{1, 12,  0,  0, 1, 1, 0, 0};   // vsync released
      tbl[14] = '{0,  1,  0,  1, 1, 1, 0, 0};

      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("power_on");

      @(negedge clk);
      reset_n = 1'b1;
      release_model();

      reached = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (fs_seen >= 2 && m_h == 10 && m_v == 5) begin
            reached = 1'b1;
            break;
         end
         step();
      end
      chk("reach_mid_frame", 32'(reached), 32'd1);
      chk("mid_frame_col", col, 32'd10);

      // Mid-frame reset: outputs must clear before any further clock edge.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_reset("async");
      repeat (3) @(posedge clk);
      #1;
      chk_reset("held");
      @(negedge clk);
      reset_n = 1'b1;
      release_model();

      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         n++;
         if (col != 32'd0) break;
      end
      chk("restart_latency", 32'(n), 32'(CLK_DIV));
      $display("restart: col left 0 after %0d clks", n);

      for (int i = 0; i < 800; i++) step();

      chk("max_col", 32'(max_col), 32'(HV - 1));
      chk("max_row", 32'(max_row), 32'(VV - 1));
      chk("frames_seen", 32'(fs_seen), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scan_generator.md
VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel.
REQ-002 SHALL have parameter H_VISIBLE, default 640, meaning visible columns.
REQ-003 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameter V_VISIBLE, default 480, meaning visible rows.
REQ-005 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, meaning vertical porch and sync widths in lines.
REQ-006 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports col, row  out  32 (int)  pixel coordinate presented to the drawer.
REQ-009 SHALL have ports red_in, green_in, blue_in  in  4 each  drawer colour for the presented col/row.
REQ-010 SHALL have ports vga_red, vga_green, vga_blue  out  4 each  DAC colour.
REQ-011 SHALL have ports vga_hsync, vga_vsync  out  1 each  active-low sync.
REQ-012 SHALL have port pixel_tick  out  1  one-clk strobe per pixel.
REQ-013 SHALL have port frame_start  out  1  one-clk strobe at the first pixel of each frame.

Function
REQ-014 SHALL count a divider 0..CLK_DIV-1 and assert pixel_tick for the clk in which the divider equals CLK_DIV-1; CLK_DIV=1 keeps pixel_tick high continuously.
REQ-015 SHALL advance h_count 0..H_TOTAL-1 (H_TOTAL=800) only on pixel_tick, wrapping to 0.
REQ-016 SHALL advance v_count 0..V_TOTAL-1 (V_TOTAL=525) only on pixel_tick when h_count wraps; at h=799,v=524 both wrap to 0 on the same tick.
REQ-017 SHALL define active as h_count<H_VISIBLE and v_count<V_VISIBLE.
REQ-018 SHALL drive col=h_count and row=v_count while active, and col=0,row=0 during blanking, so drawer array indices never exceed 15 (col/40) and 11 (row/40).
REQ-019 SHALL compute raw hsync low for h_count in [656,751] and raw vsync low for v_count in [490,491], high otherwise.
REQ-020 SHALL register, on each pixel_tick, vga_rgb = active ? {red_in,green_in,blue_in} : 0, and vga_hsync/vga_vsync from raw syncs of the same count, giving 1-pixel latency with colour and syncs aligned.
REQ-021 SHALL hold all outputs stable between pixel_ticks.
REQ-022 SHALL pulse frame_start with the pixel_tick on which h_count and v_count become 0.
REQ-023 SHALL treat red_in/green_in/blue_in as combinational from col/row, sampled only at pixel_tick.

Reset
REQ-024 SHALL, while reset_n=0, force divider, h_count, v_count, col, row to 0; vga_red/green/blue to 0; vga_hsync, vga_vsync to 1; pixel_tick, frame_start to 0.
REQ-025 SHALL, on reset release mid-frame, restart at h=0,v=0 with no partial sync pulse emitted; first pixel_tick occurs CLK_DIV clks after release.

Structure
REQ-026 SHALL place timing defaults, H_TOTAL, V_TOTAL and sync start/end constants in shared package vga_pkg.
REQ-027 SHALL use one sub-module, vga_axis_counter (parameterised count, wrap flag, visible flag, sync window), instantiated for horizontal and vertical.

Verification
REQ-028 Reset then run 2 frames at CLK_DIV=2 -> 840000 clks between frame_start pulses; 420000 pixel_ticks per frame.
REQ-029 Count hsync per line -> low exactly 96 pixel_ticks, beginning 16 ticks after col 639; vsync low exactly 2 lines (1600 ticks) beginning at line 490.
REQ-030 Drive red_in=col[3:0] -> vga_red at tick k equals col of tick k-1; vga_* = 0 for every blanking pixel.
REQ-031 Observe h=799,v=524 -> next tick h=0,v=0, frame_start=1, col=row=0.
REQ-032 Assert reset_n=0 at v=300,h=400 for 3 clks -> outputs equal REQ-024 values asynchronously; after release, col=0,row=0 and counting restarts.
REQ-033 Check col/row over full frame -> col never >639, row never >479.
